dmem_arbiter: RTL and testbench

// - Shares the single-port word-wide DataMem between two requesters:

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane.sv | 58 +++++
 rtl/dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DataMem arbiter: access sizes, FSM states,
// and the alignment rule applied to every request.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_BAD = 2'b11
   } size_t;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      MERGE,
      RESP,
      ERRRSP
   } state_t;

   // Illegal size, or a half/word access that straddles its natural boundary.
   function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_H:    bad = lane[0];
         SZ_W:    bad = (lane != 2'b00);
         SZ_BAD:  bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian byte-lane steering: load extract with sign/zero extension,
// and the store merge used by the read-modify-write of sub-word stores.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] rword_i,
   input  logic [1:0]  lane_i,
   input  size_t       size_i,
   input  logic        unsign_i,
   output logic [31:0] load_o,
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rword_i[7:0];
      case (lane_i)
         2'd1:    byte_sel = rword_i[15:8];
         2'd2:    byte_sel = rword_i[23:16];
         2'd3:    byte_sel = rword_i[31:24];
         default: byte_sel = rword_i[7:0];
      endcase
      half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
   end

   always_comb begin
      load_o = rword_i;
      case (size_i)
         SZ_B:    load_o = unsign_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    load_o = unsign_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_o = rword_i;
      endcase
   end

   always_comb begin
      merge_o = old_i;
      case (size_i)
         SZ_B: begin
            case (lane_i)
               2'd1:    merge_o[15:8]  = new_i[7:0];
               2'd2:    merge_o[23:16] = new_i[7:0];
               2'd3:    merge_o[31:24] = new_i[7:0];
               default: merge_o[7:0]   = new_i[7:0];
            endcase
         end
         SZ_H: begin
            if (lane_i[1]) merge_o[31:16] = new_i[15:0];
            else           merge_o[15:0]  = new_i[15:0];
         end
         default: merge_o = new_i;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMem: grants one request at
// a time, sequences the memory access and returns a one-cycle response.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter bit          PRIO_FIXED = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             reqValid,
   output logic [1:0]             reqReady,
   input  logic [1:0]             reqWrite,
   input  logic [1:0][1:0]        reqSize,
   input  logic [1:0]             reqUnsign,
   input  logic [1:0][ADDR_W-1:0] reqAddr,
   input  logic [1:0][DATA_W-1:0] reqWData,
   output logic [1:0]             rspValid,
   output logic [DATA_W-1:0]      rspData,
   output logic                   rspErr,
   output logic [ADDR_W-1:0]      memAddr,
   output logic [DATA_W-1:0]      memWData,
   input  logic [DATA_W-1:0]      memRData,
   output logic                   memR,
   output logic                   memW
);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                port_q, port_d;
   logic                wr_q, wr_d;
   size_t               size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          lane_q, lane_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;

   logic                memR_q, memR_d;
   logic                memW_q, memW_d;
   logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
   logic [DATA_W-1:0]   memWData_q, memWData_d;
   logic [1:0]          rspValid_q, rspValid_d;
   logic [DATA_W-1:0]   rspData_q, rspData_d;
   logic                rspErr_q, rspErr_d;

   logic                gnt;
   logic                hs;
   size_t               req_sz;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_bad;
   logic [1:0]          port_mask;
   logic [31:0]         load_data;
   logic [31:0]         merge_data;

   always_comb begin
      if (reqValid == 2'b11) gnt = PRIO_FIXED ? 1'b0 : ~last_q;
      else                   gnt = reqValid[1];
   end

   assign reqReady  = (state_q == IDLE) ? (reqValid & (gnt ? 2'b10 : 2'b01)) : 2'b00;
   assign hs        = |reqReady;
   assign req_sz    = size_t'(reqSize[gnt]);
   assign req_addr  = reqAddr[gnt];
   assign req_bad   = is_misaligned(req_sz, req_addr[1:0]);
   assign port_mask = port_q ? 2'b10 : 2'b01;

   dmem_lane u_lane (
      .rword_i  (memRData),
      .lane_i   (lane_q),
      .size_i   (size_q),
      .unsign_i (uns_q),
      .load_o   (load_data),
      .old_i    (memRData),
      .new_i    (wdata_q),
      .merge_o  (merge_data)
   );

   // Outputs are computed for the state being entered, so every mem*/rsp*
   // pin is a flop; an error request spends its ACCESS slot idle so its
   // response lands on the same cycle as a load's.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      port_d     = port_q;
      wr_d       = wr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      memR_d     = 1'b0;
      memW_d     = 1'b0;
      memAddr_d  = memAddr_q;
      memWData_d = memWData_q;
      rspValid_d = '0;
      rspData_d  = '0;
      rspErr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (hs) begin
               port_d    = gnt;
               last_d    = gnt;
               wr_d      = reqWrite[gnt];
               size_d    = req_sz;
               uns_d     = reqUnsign[gnt];
               lane_d    = req_addr[1:0];
               wdata_d   = reqWData[gnt];
               err_d     = req_bad;
               memAddr_d = {req_addr[ADDR_W-1:2], 2'b00};
               state_d   = ACCESS;
               if (!req_bad) begin
                  if (reqWrite[gnt] && (req_sz == SZ_W)) begin
                     memW_d     = 1'b1;
                     memWData_d = reqWData[gnt];
                  end else begin
                     memR_d = 1'b1;
                  end
               end
            end
         end
         ACCESS: begin
            if (err_q) begin
               rspValid_d = port_mask;
               rspErr_d   = 1'b1;
               state_d    = ERRRSP;
            end else if (!wr_q) begin
               rspValid_d = port_mask;
               rspData_d  = load_data;
               state_d    = RESP;
            end else if (size_q == SZ_W) begin
               rspValid_d = port_mask;
               state_d    = RESP;
            end else begin
               memW_d     = 1'b1;
               memWData_d = merge_data;
               state_d    = MERGE;
            end
         end
         MERGE: begin
            rspValid_d = port_mask;
            state_d    = RESP;
         end
         RESP:    state_d = IDLE;
         ERRRSP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         port_q     <= 1'b0;
         wr_q       <= 1'b0;
         size_q     <= SZ_B;
         uns_q      <= 1'b0;
         lane_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         memR_q     <= 1'b0;
         memW_q     <= 1'b0;
         memAddr_q  <= '0;
         memWData_q <= '0;
         rspValid_q <= '0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         port_q     <= port_d;
         wr_q       <= wr_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         memR_q     <= memR_d;
         memW_q     <= memW_d;
         memAddr_q  <= memAddr_d;
         memWData_q <= memWData_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
         rspErr_q   <= rspErr_d;
      end
   end

   assign memR     = memR_q;
   assign memW     = memW_q;
   assign memAddr  = memAddr_q;
   assign memWData = memWData_q;
   assign rspValid = rspValid_q;
   assign rspData  = rspData_q;
   assign rspErr   = rspErr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a request-level reference model predicts
// every cycle of the memory and response pins; literal vectors pin the model.
module tb_dmem_arbiter;

   localparam int K_LD = 0;
   localparam int K_WS = 1;
   localparam int K_SS = 2;
   localparam int K_ER = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       reqValid, reqWrite, reqUnsign;
   logic [1:0][1:0]  reqSize;
   logic [1:0][31:0] reqAddr, reqWData;
   logic [1:0]       reqReady, rspValid;
   logic [31:0]      rspData, memAddr, memWData, memRData;
   logic             rspErr, memR, memW;

   logic [1:0]       f_reqReady, f_rspValid;
   logic [31:0]      f_rspData, f_memAddr, f_memWData;
   logic [31:0]      f_memRData = 32'h0;
   logic             f_rspErr, f_memR, f_memW;

   logic [31:0] dmem    [16];
   logic [31:0] ref_mem [16];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
      .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsign(reqUnsign),
      .reqAddr(reqAddr), .reqWData(reqWData), .rspValid(rspValid),
      .rspData(rspData), .rspErr(rspErr), .memAddr(memAddr),
      .memWData(memWData), .memRData(memRData), .memR(memR), .memW(memW)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(1'b1)) u_fix (
      .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(f_reqReady),
      .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsign(reqUnsign),
      .reqAddr(reqAddr), .reqWData(reqWData), .rspValid(f_rspValid),
      .rspData(f_rspData), .rspErr(f_rspErr), .memAddr(f_memAddr),
      .memWData(f_memWData), .memRData(f_memRData), .memR(f_memR), .memW(f_memW)
   );

   assign memRData = memR ? dmem[memAddr[5:2]] : 32'h0;

   always @(posedge clk) if (memW) dmem[memAddr[5:2]] <= memWData;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int sh;
      v = w;
      if (sz == 2'd0) begin
         sh = int'(a) * 8;
         v = (w >> sh) & 32'hff;
         if (!uns && v[7]) v = v | 32'hffffff00;
      end else if (sz == 2'd1) begin
         sh = int'(a[1]) * 16;
         v = (w >> sh) & 32'hffff;
         if (!uns && v[15]) v = v | 32'hffff0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] a, input logic [1:0] sz);
      logic [31:0] mask;
      int sh;
      if (sz == 2'd2) return wd;
      sh   = (sz == 2'd0) ? int'(a) * 8 : int'(a[1]) * 16;
      mask = ((sz == 2'd0) ? 32'hff : 32'hffff) << sh;
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   function automatic bit m_bad(input logic [1:0] sz, input logic [1:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
   endfunction

   bit          m_act = 1'b0;
   bit          m_last = 1'b1;
   int          m_p, m_kind, m_t0, m_lat;
   logic [31:0] m_addr, m_wd;
   logic [1:0]  m_sz;
   logic        m_uns;
   int          gq[$];

   always @(negedge clk) begin : compare
      int k, w, idx;
      bit eR, eW, eV;
      logic [31:0] ewd, edat;
      logic [1:0] erdy;
      cyc++;
      if (!rst_n) begin
         chk("rst_reqReady", reqReady, 0);
         chk("rst_rspValid", rspValid, 0);
         chk("rst_rspData", rspData, 0);
         chk("rst_rspErr", rspErr, 0);
         chk("rst_memR", memR, 0);
         chk("rst_memW", memW, 0);
         chk("rst_memAddr", memAddr, 0);
         chk("rst_memWData", memWData, 0);
         m_act  = 1'b0;
         m_last = 1'b1;
      end else begin
         k = cyc - m_t0;
         idx = int'(m_addr[5:2]);
         eR = 0; eW = 0; eV = 0; ewd = 0; edat = 0;
         if (m_act) begin
            case (m_kind)
               K_LD: begin
                  eR = (k == 1);
                  eV = (k == 2);
                  if (eV) edat = m_extract(ref_mem[idx], m_addr[1:0], m_sz, m_uns);
               end
               K_WS: begin
                  eW = (k == 1);
                  ewd = m_wd;
                  eV = (k == 2);
               end
               K_SS: begin
                  eR = (k == 1);
                  eW = (k == 2);
                  ewd = m_merge(ref_mem[idx], m_wd, m_addr[1:0], m_sz);
                  eV = (k == 3);
               end
               default: eV = (k == 2);
            endcase
         end
         chk("memR", memR, eR);
         chk("memW", memW, eW);
         chk("rspValid", rspValid, eV ? (2'b01 << m_p) : 2'b00);
         if (eR || eW) chk("memAddr", memAddr, {m_addr[31:2], 2'b00});
         if (eW) begin
            chk("memWData", memWData, ewd);
            ref_mem[idx] = ewd;
         end
         if (eV) begin
            chk("rspErr", rspErr, m_kind == K_ER);
            chk("rspData", rspData, edat);
         end

         w = 0;
         erdy = 2'b00;
         if (!m_act && reqValid != 2'b00) begin
            if (reqValid == 2'b11) w = m_last ? 0 : 1;
            else                   w = reqValid[1] ? 1 : 0;
            erdy = 2'b01 << w;
         end
         chk("reqReady", reqReady, erdy);

         if (!m_act && reqValid != 2'b00) begin
            m_p    = w;
            m_addr = reqAddr[w];
            m_wd   = reqWData[w];
            m_sz   = reqSize[w];
            m_uns  = reqUnsign[w];
            if (m_bad(m_sz, m_addr[1:0])) m_kind = K_ER;
            else if (!reqWrite[w])        m_kind = K_LD;
            else if (m_sz == 2'd2)        m_kind = K_WS;
            else                          m_kind = K_SS;
            m_lat  = (m_kind == K_SS) ? 3 : 2;
            m_t0   = cyc;
            m_act  = 1'b1;
            m_last = (w == 1);
            gq.push_back(w);
         end else if (m_act && k == m_lat) begin
            m_act = 1'b0;
         end
      end
   end

   bit cnt_en = 1'b0;
   int d0 = 0, d1 = 0, f0 = 0, f1 = 0;
   always @(negedge clk) begin
      if (cnt_en) begin
         if (rspValid[0])   d0++;
         if (rspValid[1])   d1++;
         if (f_rspValid[0]) f0++;
         if (f_rspValid[1]) f1++;
      end
   end

   task automatic do_req(input int p, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      bit got;
      got = 0; lat = -1; rd = '0; er = 1'b0;
      @(posedge clk); #1;
      reqWrite[p] = wr; reqSize[p] = sz; reqUnsign[p] = uns;
      reqAddr[p] = a; reqWData[p] = wd; reqValid[p] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (reqReady[p]) begin got = 1; break; end
      end
      @(posedge clk); #1 reqValid[p] = 1'b0;
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL handshake_timeout: port %0d got no reqReady, required within 20 cycles", p);
         return;
      end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (rspValid[p]) begin lat = k; rd = rspData; er = rspErr; break; end
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      reqValid = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] rd;
      logic er;
      int lat;
      bit got;
      reqValid = '0; reqWrite = '0; reqUnsign = '0;
      reqSize = '0; reqAddr = '0; reqWData = '0;
      for (int i = 0; i < 16; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_req(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'ha28b538c, rd, er, lat);
      chk("sw_lat", lat, 2);
      chk("sw_mem", dmem[0], 32'ha28b538c);
      do_req(1, 1'b1, 2'b00, 1'b0, 32'h3, 32'h5a, rd, er, lat);
      chk("sb_lat", lat, 3);
      chk("sb_mem", dmem[0], 32'h5a8b538c);

      do_req(0, 1'b0, 2'b00, 1'b0, 32'h2, 0, rd, er, lat);
      chk("lb_s_data", rd, 32'hffffff8b);
      chk("lb_s_lat", lat, 2);
      do_req(1, 1'b0, 2'b00, 1'b1, 32'h2, 0, rd, er, lat);
      chk("lb_u_data", rd, 32'h0000008b);
      do_req(0, 1'b0, 2'b01, 1'b0, 32'h2, 0, rd, er, lat);
      chk("lh_data", rd, 32'h00005a8b);
      do_req(1, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
      chk("lw_data", rd, 32'h5a8b538c);

      do_req(1, 1'b0, 2'b10, 1'b0, 32'h2, 0, rd, er, lat);
      chk("lw_mis_err", er, 1);
      chk("lw_mis_lat", lat, 2);
      chk("lw_mis_data", rd, 0);
      do_req(0, 1'b1, 2'b11, 1'b0, 32'h0, 32'hdeadbeef, rd, er, lat);
      chk("sz11_err", er, 1);
      chk("sz11_mem", dmem[0], 32'h5a8b538c);

      do_req(1, 1'b1, 2'b01, 1'b0, 32'h6, 32'hffff1234, rd, er, lat);
      chk("sh_mem", dmem[1], 32'h12340000);
      do_req(0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h80, rd, er, lat);
      chk("sb5_mem", dmem[1], 32'h12348000);
      do_req(0, 1'b0, 2'b00, 1'b0, 32'h5, 0, rd, er, lat);
      chk("lb5_data", rd, 32'hffffff80);
      do_req(1, 1'b0, 2'b01, 1'b1, 32'h4, 0, rd, er, lat);
      chk("lhu4_data", rd, 32'h00008000);
      do_req(1, 1'b0, 2'b01, 1'b0, 32'h6, 0, rd, er, lat);
      chk("lh6_data", rd, 32'h00001234);

      apply_reset();
      gq.delete();
      @(posedge clk); #1;
      reqWrite = 2'b00; reqSize[0] = 2'b10; reqSize[1] = 2'b10;
      reqAddr[0] = 32'h0; reqAddr[1] = 32'h4;
      reqValid = 2'b11;
      cnt_en = 1'b1;
      repeat (14) @(posedge clk);
      #1 reqValid = 2'b00;
      repeat (5) @(posedge clk);
      #1 cnt_en = 1'b0;
      for (int i = 0; i < 4; i++)
         chk("grant_order", (i < gq.size()) ? gq[i] : 99, i % 2);
      chk("rr_p0_served", d0 >= 2, 1);
      chk("rr_p1_served", d1 >= 2, 1);
      chk("fix_p1_starved", f1, 0);
      chk("fix_p0_served", f0 >= 3, 1);

      apply_reset();
      @(posedge clk); #1;
      reqWrite[0] = 1'b1; reqSize[0] = 2'b00; reqUnsign[0] = 1'b0;
      reqAddr[0] = 32'h0; reqWData[0] = 32'hff; reqValid[0] = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (reqReady[0]) begin got = 1; break; end
      end
      chk("abort_handshake", got, 1);
      @(posedge clk); #1 reqValid[0] = 1'b0;
      @(posedge clk); #1;
      chk("merge_memW", memW, 1);
      chk("merge_memWData", memWData, 32'h5a8b53ff);
      rst_n = 1'b0;
      #1 chk("abort_memW", memW, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_mem", dmem[0], 32'h5a8b538c);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
      chk("abort_lw", rd, 32'h5a8b538c);
      chk("abort_lw_err", er, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
